// File: rtl/vital_sign_pkg.sv
// Shared definitions for the vital-sign alarm FSM: state encoding and
// bit positions of the six risk flags inside the sensor vector.
package vital_sign_pkg;

   typedef enum logic [1:0] {
      S0 = 2'b00,  // NORMAL
      S1 = 2'b01,  // WARNING
      S2 = 2'b10   // CRISIS; 2'b11 is unused and decoded as illegal
   } state_t;

   localparam int SENSOR_W = 6;

   localparam int IDX_H = 5;
   localparam int IDX_P = 4;
   localparam int IDX_O = 3;
   localparam int IDX_T = 2;
   localparam int IDX_R = 1;
   localparam int IDX_B = 0;

endpackage

// File: rtl/fsm_vital_sign.sv
// Three-level patient alarm FSM: grades six risk flags into NORMAL/WARNING/CRISIS
// and drives alarms and mitigations from registered state and sampled flags only.
module fsm_vital_sign
   import vital_sign_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic H,
   input  logic P,
   input  logic O,
   input  logic T,
   input  logic R,
   input  logic B,
   output logic Buzzer,
   output logic LED,
   output logic Vibrator,
   output logic Micro_Fan,
   output logic Selenoid_Valve,
   output logic Infuse_Pump
);

   state_t              state;
   state_t              state_next;
   logic [SENSOR_W-1:0] flags;
   logic [SENSOR_W-1:0] sample;
   logic                any_risk;
   logic                total_crisis;
   logic                unused_flags;

   assign flags = {H, P, O, T, R, B};

   // Next state depends only on the current flags, so any state (even 2'b11)
   // lands on a legal state after one edge.
   always_comb begin
      any_risk     = |flags;
      total_crisis = &flags;
      state_next   = S0;
      if (total_crisis) begin
         state_next = S2;
      end else if (any_risk) begin
         state_next = S1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= S0;
         sample <= '0;
      end else begin
         state  <= state_next;
         sample <= flags;
      end
   end

   always_comb begin
      Buzzer         = 1'b0;
      LED            = 1'b0;
      Vibrator       = 1'b0;
      Micro_Fan      = 1'b0;
      Selenoid_Valve = 1'b0;
      Infuse_Pump    = 1'b0;
      case (state)
         S1: begin
            LED            = 1'b1;
            Vibrator       = 1'b1;
            Micro_Fan      = sample[IDX_T];
            Selenoid_Valve = sample[IDX_O];
            Infuse_Pump    = sample[IDX_B];
         end
         S2: begin
            Buzzer         = 1'b1;
            LED            = 1'b1;
            Vibrator       = 1'b1;
            Micro_Fan      = sample[IDX_T];
            Selenoid_Valve = sample[IDX_O];
            Infuse_Pump    = sample[IDX_B];
         end
         default: ;
      endcase
   end

   // H, P and R are held in the sample for completeness but only steer the state.
   assign unused_flags = ^{sample[IDX_H], sample[IDX_P], sample[IDX_R]};

endmodule

// File: tb/tb_fsm_vital_sign.sv
// Scoreboard bench for fsm_vital_sign: directed scenarios plus random flags,
// checked every cycle against a severity-grading reference model.
module tb_fsm_vital_sign;

   logic clk;
   logic reset;
   logic H, P, O, T, R, B;
   logic Buzzer, LED, Vibrator, Micro_Fan, Selenoid_Valve, Infuse_Pump;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [5:0] want;
      string      tag;
   } exp_t;

   exp_t sb[$];

   fsm_vital_sign dut (
      .clk            (clk),
      .reset          (reset),
      .H              (H),
      .P              (P),
      .O              (O),
      .T              (T),
      .R              (R),
      .B              (B),
      .Buzzer         (Buzzer),
      .LED            (LED),
      .Vibrator       (Vibrator),
      .Micro_Fan      (Micro_Fan),
      .Selenoid_Valve (Selenoid_Valve),
      .Infuse_Pump    (Infuse_Pump)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: severity is "all six at risk" -> crisis, "any at risk" -> warning,
   // otherwise normal. Outputs {Buzzer,LED,Vibrator,Fan,Valve,Pump} follow severity.
   // f is {H,P,O,T,R,B}.
   function automatic logic [5:0] model(input logic rst_n, input logic [5:0] f);
      int  n_risk;
      bit  crisis;
      bit  alarm;
      if (!rst_n) return 6'b000000;
      n_risk = 0;
      for (int i = 0; i < 6; i++) n_risk += int'(f[i]);
      crisis = (n_risk == 6);
      alarm  = (n_risk > 0);
      return {crisis, alarm, alarm, alarm & f[2], alarm & f[3], alarm & f[0]};
   endfunction

   task automatic step(input logic r, input logic [5:0] f, input string tag);
      exp_t e;
      @(negedge clk);
      reset = r;
      {H, P, O, T, R, B} = f;
      e.want = model(r, f);
      e.tag  = tag;
      sb.push_back(e);
   endtask

   // Monitor: after each active edge the DUT presents a new output word.
   initial begin
      exp_t       e;
      logic [5:0] got;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (sb.size() > 0) begin
            e   = sb.pop_front();
            got = {Buzzer, LED, Vibrator, Micro_Fan, Selenoid_Valve, Infuse_Pump};
            total++;
            if (got !== e.want) begin
               bad++;
               $display("FAIL %s cyc=%0d outputs got=%b want=%b", e.tag, cyc, got, e.want);
            end
         end
      end
   end

   initial begin
      logic [5:0] f;
      int         kind;
      int         wait_cnt;
      reset = 1'b0;
      {H, P, O, T, R, B} = 6'b000000;

      step(1'b0, 6'b000000, "reset0");
      step(1'b0, 6'b000000, "reset1");
      step(1'b1, 6'b000000, "normal");
      step(1'b1, 6'b100000, "h_warn0");
      step(1'b1, 6'b100000, "h_warn1");
      step(1'b1, 6'b111111, "s1_to_crisis");
      step(1'b1, 6'b001110, "crisis_to_warn");
      step(1'b1, 6'b000000, "warn_to_normal");
      step(1'b1, 6'b111111, "normal_to_crisis");
      step(1'b0, 6'b111111, "reset_in_crisis");
      step(1'b1, 6'b111111, "crisis_again");
      step(1'b1, 6'b000000, "crisis_to_normal");
      step(1'b1, 6'b010010, "p_r_only");
      step(1'b1, 6'b111111, "crisis_b");
      step(1'b1, 6'b000001, "crisis_to_warn_b");
      step(1'b1, 6'b111110, "five_of_six");

      for (int i = 0; i < 400; i++) begin
         kind = int'($urandom_range(0, 9));
         if (kind == 0)      f = 6'b111111;
         else if (kind == 1) f = 6'b000000;
         else                f = 6'($urandom);
         step(($urandom_range(0, 15) != 0), f, "random");
      end

      wait_cnt = 0;
      while (sb.size() > 0 && wait_cnt < 10) begin
         @(negedge clk);
         wait_cnt++;
      end
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain pending got=%0d want=0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
